// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter and its picker.
package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    localparam int WB_ARB_MAX_MASTERS = 8;

    // Index of the set bit in a one-hot vector; zero when no bit is set.
    function automatic logic [2:0] onehot_to_idx(input logic [WB_ARB_MAX_MASTERS-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < WB_ARB_MAX_MASTERS; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after 'last', wrapping around.
module rr_picker #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  pick,
    output logic          valid
);

    always_comb begin
        logic [IW-1:0] idx;
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        // Offset N revisits 'last' itself, so a lone requester can win again.
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last) + k) % N);
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: holds the grant for a whole CYC burst and aborts
// slave cycles that stall past TIMEOUT with an ERR to the owning master.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_cyc,
    input  logic [NUM_MASTERS-1:0]            m_stb,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_w,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [NUM_MASTERS-1:0]            m_err,
    output logic [DATA_WIDTH-1:0]             m_dat_r,
    output logic                              s_cyc,
    output logic                              s_stb,
    output logic                              s_we,
    output logic [ADDR_WIDTH-1:0]             s_adr,
    output logic [DATA_WIDTH-1:0]             s_dat_w,
    input  logic                              s_ack,
    input  logic                              s_err,
    input  logic [DATA_WIDTH-1:0]             s_dat_r,
    output logic [NUM_MASTERS-1:0]            gnt,
    output logic                              timeout_evt
);

    localparam int IDX_W          = $clog2(NUM_MASTERS);
    localparam int WB_ARB_TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [WB_ARB_TIMER_W-1:0] TIMER_LAST = WB_ARB_TIMER_W'(TIMEOUT - 1);

    arb_state_t                state_q, state_d;
    logic [NUM_MASTERS-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]          last_q, last_d;
    logic [WB_ARB_TIMER_W-1:0] timer_q, timer_d;
    logic                      evt_q, evt_d;

    logic [NUM_MASTERS-1:0]    pick;
    logic                      pick_valid;
    logic [IDX_W-1:0]          pick_idx;
    logic                      cyc_g, stb_g;
    logic                      bus_active, ack_route, err_route;

    rr_picker #(.N(NUM_MASTERS)) u_picker (
        .req   (m_cyc),
        .last  (last_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    assign pick_idx = IDX_W'(onehot_to_idx(WB_ARB_MAX_MASTERS'(pick)));

    // While granted, last_q doubles as the index of the owning master.
    assign cyc_g = m_cyc[last_q];
    assign stb_g = m_stb[last_q];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        timer_d = timer_q;
        evt_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (pick_valid) begin
                    gnt_d   = pick;
                    last_d  = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!cyc_g) begin
                    gnt_d   = '0;
                    timer_d = '0;
                    state_d = IDLE;
                end else if (stb_g && !s_ack && !s_err) begin
                    if (timer_q == TIMER_LAST) begin
                        timer_d = '0;
                        evt_d   = 1'b1;
                        state_d = ABORT;
                    end else if (timer_q != '1) begin
                        timer_d = timer_q + 1'b1;
                    end
                end else begin
                    timer_d = '0;
                end
            end
            ABORT: begin
                if (!cyc_g) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IDX_W'(NUM_MASTERS - 1);
            timer_q <= '0;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            evt_q   <= evt_d;
        end
    end

    // Reset gates the bus immediately so a sampled reset never lets a beat complete.
    assign bus_active = (state_q == GRANT) && !reset;
    assign ack_route  = bus_active && s_ack;
    // evt_q is high only in the first ABORT cycle, which is when the abort ERR is due.
    assign err_route  = !reset && (((state_q == GRANT) && s_err) ||
                                   ((state_q == ABORT) && evt_q));

    assign s_cyc   = bus_active && cyc_g;
    assign s_stb   = bus_active && stb_g;
    assign s_we    = bus_active && m_we[last_q];
    assign s_adr   = bus_active ? m_adr[last_q*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign s_dat_w = bus_active ? m_dat_w[last_q*DATA_WIDTH +: DATA_WIDTH] : '0;

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_route
            assign m_ack[gi] = gnt_q[gi] && ack_route;
            assign m_err[gi] = gnt_q[gi] && err_route;
        end
    endgenerate

    assign m_dat_r     = s_dat_r;
    assign gnt         = gnt_q;
    assign timeout_evt = evt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: per-cycle vector table plus a timeout latency sequence.
module tb_wb_arbiter;

    localparam logic [15:0] ADR0 = 16'h1234;
    localparam logic [15:0] ADR1 = 16'hA5A0;
    localparam logic [15:0] DAT0 = 16'h1111;
    localparam logic [15:0] DAT1 = 16'h2222;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [31:0] m_adr, m_dat_w;
    logic [1:0]  m_ack, m_err;
    logic [15:0] m_dat_r;
    logic        s_cyc, s_stb, s_we;
    logic [15:0] s_adr, s_dat_w;
    logic        s_ack, s_err;
    logic [15:0] s_dat_r;
    logic [1:0]  gnt;
    logic        timeout_evt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .NUM_MASTERS (2),
        .ADDR_WIDTH  (16),
        .DATA_WIDTH  (16),
        .TIMEOUT     (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_cyc       (m_cyc),
        .m_stb       (m_stb),
        .m_we        (m_we),
        .m_adr       (m_adr),
        .m_dat_w     (m_dat_w),
        .m_ack       (m_ack),
        .m_err       (m_err),
        .m_dat_r     (m_dat_r),
        .s_cyc       (s_cyc),
        .s_stb       (s_stb),
        .s_we        (s_we),
        .s_adr       (s_adr),
        .s_dat_w     (s_dat_w),
        .s_ack       (s_ack),
        .s_err       (s_err),
        .s_dat_r     (s_dat_r),
        .gnt         (gnt),
        .timeout_evt (timeout_evt)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic        ack;
        logic        err;
        logic [15:0] sdat;
        logic [1:0]  gnt;
        logic        scyc;
        logic        sstb;
        logic [1:0]  mack;
        logic [1:0]  merr;
        logic        evt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [1:0] cyc, input logic [1:0] stb,
                       input logic ack, input logic err, input logic [15:0] sdat,
                       input logic [1:0] g, input logic scyc, input logic sstb,
                       input logic [1:0] mack, input logic [1:0] merr, input logic evt);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.stb = stb; v.ack = ack; v.err = err; v.sdat = sdat;
        v.gnt = g; v.scyc = scyc; v.sstb = sstb; v.mack = mack; v.merr = merr; v.evt = evt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    initial begin
        int stb_seen;
        int evt_seen;
        logic       evt_scyc;
        logic [1:0] evt_merr;

        reset   = 1'b1;
        m_cyc   = 2'b00;
        m_stb   = 2'b00;
        m_we    = 2'b10;
        m_adr   = {ADR1, ADR0};
        m_dat_w = {DAT1, DAT0};
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_dat_r = 16'h0000;

        // Single request from master 0, with a stray STB-without-CYC on master 1.
        add(1, 2'b00, 2'b00, 0, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 0);
        add(0, 2'b00, 2'b10, 0, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 0);
        add(0, 2'b01, 2'b01, 0, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 0);
        add(0, 2'b01, 2'b01, 0, 0, 16'h0000, 2'b01, 1, 1, 2'b00, 2'b00, 0);
        add(0, 2'b01, 2'b01, 0, 0, 16'h0000, 2'b01, 1, 1, 2'b00, 2'b00, 0);
        add(0, 2'b01, 2'b01, 1, 0, 16'hBEEF, 2'b01, 1, 1, 2'b01, 2'b00, 0);
        add(0, 2'b00, 2'b00, 0, 0, 16'h0000, 2'b01, 0, 0, 2'b00, 2'b00, 0);
        add(0, 2'b00, 2'b00, 0, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 0);

        // Fairness: both masters keep requesting; order must alternate 0,1,0,1,0,1.
        add(1, 2'b11, 2'b11, 0, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 0);
        for (int k = 0; k < 6; k++) begin
            logic [1:0] g;
            g = (k % 2 == 1) ? 2'b10 : 2'b01;
            add(0, 2'b11, 2'b11, 0, 0, 16'(k), 2'b00, 0, 0, 2'b00, 2'b00, 0);
            add(0, 2'b11, 2'b11, 1, 0, 16'(k), g,     1, 1, g,     2'b00, 0);
            add(0, ~g,    ~g,    0, 0, 16'(k), g,     0, 0, 2'b00, 2'b00, 0);
        end

        // Burst lock: master 0 holds CYC for four beats while master 1 waits.
        add(1, 2'b00, 2'b00, 0, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 0);
        add(0, 2'b11, 2'b11, 0, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 0);
        add(0, 2'b11, 2'b11, 1, 0, 16'h1001, 2'b01, 1, 1, 2'b01, 2'b00, 0);
        add(0, 2'b11, 2'b11, 0, 1, 16'h1002, 2'b01, 1, 1, 2'b00, 2'b01, 0);
        add(0, 2'b11, 2'b11, 1, 0, 16'h1003, 2'b01, 1, 1, 2'b01, 2'b00, 0);
        add(0, 2'b11, 2'b11, 1, 0, 16'h1004, 2'b01, 1, 1, 2'b01, 2'b00, 0);
        add(0, 2'b10, 2'b10, 0, 0, 16'h0000, 2'b01, 0, 0, 2'b00, 2'b00, 0);
        add(0, 2'b10, 2'b10, 0, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 0);
        add(0, 2'b10, 2'b10, 1, 0, 16'h2001, 2'b10, 1, 1, 2'b10, 2'b00, 0);
        add(0, 2'b00, 2'b00, 0, 0, 16'h0000, 2'b10, 0, 0, 2'b00, 2'b00, 0);
        add(0, 2'b00, 2'b00, 0, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 0);

        // Timeout: 8 stalled STB cycles, then one ERR/evt cycle in ABORT.
        add(1, 2'b00, 2'b00, 0, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 0);
        add(0, 2'b01, 2'b01, 0, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 0);
        for (int k = 0; k < 8; k++) begin
            add(0, 2'b01, 2'b01, 0, 0, 16'h0000, 2'b01, 1, 1, 2'b00, 2'b00, 0);
        end
        add(0, 2'b01, 2'b01, 0, 0, 16'h0000, 2'b01, 0, 0, 2'b00, 2'b01, 1);
        add(0, 2'b01, 2'b01, 1, 0, 16'h0000, 2'b01, 0, 0, 2'b00, 2'b00, 0);
        add(0, 2'b00, 2'b00, 0, 0, 16'h0000, 2'b01, 0, 0, 2'b00, 2'b00, 0);
        add(0, 2'b00, 2'b00, 0, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 0);

        // Race: ACK lands on the threshold cycle, so no abort.
        add(0, 2'b01, 2'b01, 0, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 0);
        for (int k = 0; k < 7; k++) begin
            add(0, 2'b01, 2'b01, 0, 0, 16'h0000, 2'b01, 1, 1, 2'b00, 2'b00, 0);
        end
        add(0, 2'b01, 2'b01, 1, 0, 16'hCAFE, 2'b01, 1, 1, 2'b01, 2'b00, 0);
        add(0, 2'b01, 2'b01, 0, 0, 16'h0000, 2'b01, 1, 1, 2'b00, 2'b00, 0);
        add(0, 2'b00, 2'b00, 0, 0, 16'h0000, 2'b01, 0, 0, 2'b00, 2'b00, 0);
        add(0, 2'b00, 2'b00, 0, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 0);

        // Reset during a granted beat; master 0 must win again afterwards.
        add(0, 2'b01, 2'b01, 0, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 0);
        add(0, 2'b01, 2'b01, 0, 0, 16'h0000, 2'b01, 1, 1, 2'b00, 2'b00, 0);
        add(1, 2'b11, 2'b11, 1, 0, 16'h0000, 2'b01, 0, 0, 2'b00, 2'b00, 0);
        add(0, 2'b11, 2'b11, 0, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 0);
        add(0, 2'b11, 2'b11, 1, 0, 16'h0000, 2'b01, 1, 1, 2'b01, 2'b00, 0);
        add(0, 2'b10, 2'b10, 0, 0, 16'h0000, 2'b01, 0, 0, 2'b00, 2'b00, 0);

        repeat (2) @(posedge clk);

        foreach (vecs[r]) begin
            vec_t v;
            v = vecs[r];
            @(negedge clk);
            reset   = v.rst;
            m_cyc   = v.cyc;
            m_stb   = v.stb;
            s_ack   = v.ack;
            s_err   = v.err;
            s_dat_r = v.sdat;
            #2;
            $display("row %0d rst=%b cyc=%b ack=%b err=%b | gnt=%b s_cyc=%b s_stb=%b s_adr=%h m_ack=%b m_err=%b evt=%b",
                     r, v.rst, v.cyc, v.ack, v.err, gnt, s_cyc, s_stb, s_adr, m_ack, m_err, timeout_evt);
            chk("gnt",         r, 32'(gnt),         32'(v.gnt));
            chk("s_cyc",       r, 32'(s_cyc),       32'(v.scyc));
            chk("s_stb",       r, 32'(s_stb),       32'(v.sstb));
            chk("m_ack",       r, 32'(m_ack),       32'(v.mack));
            chk("m_err",       r, 32'(m_err),       32'(v.merr));
            chk("timeout_evt", r, 32'(timeout_evt), 32'(v.evt));
            chk("m_dat_r",     r, 32'(m_dat_r),     32'(v.sdat));
            if (v.sstb) begin
                chk("s_adr",   r, 32'(s_adr),   32'(v.gnt[1] ? ADR1 : ADR0));
                chk("s_dat_w", r, 32'(s_dat_w), 32'(v.gnt[1] ? DAT1 : DAT0));
                chk("s_we",    r, 32'(s_we),    32'(v.gnt[1]));
            end else if (v.rst) begin
                chk("s_adr_rst", r, 32'(s_adr),   32'h0);
                chk("s_we_rst",  r, 32'(s_we),    32'h0);
                chk("s_dat_rst", r, 32'(s_dat_w), 32'h0);
            end
        end

        // Timeout latency on master 1, measured from the first slave STB cycle.
        @(negedge clk);
        reset    = 1'b0;
        m_cyc    = 2'b10;
        m_stb    = 2'b10;
        s_ack    = 1'b0;
        s_err    = 1'b0;
        s_dat_r  = 16'h0000;
        stb_seen = -1;
        evt_seen = -1;
        evt_scyc = 1'b1;
        evt_merr = 2'b00;
        for (int c = 0; c < 40 && evt_seen < 0; c++) begin
            #2;
            if (stb_seen < 0 && s_stb) stb_seen = c;
            if (timeout_evt) begin
                evt_seen = c;
                evt_scyc = s_cyc;
                evt_merr = m_err;
            end
            @(negedge clk);
        end
        $display("seq timeout m1: stb at %0d evt at %0d s_cyc=%b m_err=%b",
                 stb_seen, evt_seen, evt_scyc, evt_merr);
        chk("seq_stb_seen",  0, 32'(stb_seen >= 0), 32'h1);
        chk("seq_latency",   0, 32'(evt_seen - stb_seen), 32'd8);
        chk("seq_evt_s_cyc", 0, 32'(evt_scyc), 32'h0);
        chk("seq_evt_m_err", 0, 32'(evt_merr), 32'h2);
        #2;
        chk("seq_abort_err_once", 1, 32'(m_err), 32'h0);
        chk("seq_abort_gnt",      1, 32'(gnt),   32'h2);
        @(negedge clk);
        m_cyc = 2'b00;
        m_stb = 2'b00;
        #2;
        chk("seq_drop_gnt", 2, 32'(gnt), 32'h2);
        @(negedge clk);
        #2;
        $display("seq timeout m1: after drop gnt=%b s_cyc=%b", gnt, s_cyc);
        chk("seq_idle_gnt",   3, 32'(gnt),   32'h0);
        chk("seq_idle_s_cyc", 3, 32'(s_cyc), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
